univ_shift_reg: RTL
===================

// Module: univ_shift_reg
// PURPOSE
//   WIDTH-bit universal register built from edge-triggered D storage, one per bit.
//   Successor to the single-bit D flip-flop. Adds the following:
//     - parallel load, hold and clear
//     - shift left / shift right with serial inputs
//     - rotate left / rotate right
//     - a shift counter that flags when a full word has been serialised
//   Used as the serialiser/deserialiser and general register element in later datapaths.
// PARAMETERS
//   WIDTH      8     register width in bits (>= 2)
//   RESET_VAL  0     value loaded into q on reset (WIDTH bits)
// PORTS
//   clk     in   1                    clock; all state updates on rising edge
//   rst_n   in   1                    asynchronous reset, active low
//   en      in   1                    operation enable; 0 = hold everything
//   mode    in   3                    operation select (see BEHAVIOUR)
//   d       in   WIDTH                parallel load data
//   sin_r   in   1                    serial in for shift right (enters at MSB)
//   sin_l   in   1                    serial in for shift left (enters at LSB)
//   q       out  WIDTH                register contents
//   qn      out  WIDTH                bitwise complement of q, always ~q
//   sout_r  out  1                    q[0]; bit leaving on shift right
//   sout_l  out  1                    q[WIDTH-1]; bit leaving on shift left
//   cnt     out  $clog2(WIDTH+1)      shifts/rotates since last load/clear
//   done    out  1                    1 when cnt == WIDTH
// BEHAVIOUR
//   Reset
//   - rst_n=0 forces state immediately, independent of clk:
//     q=RESET_VAL, qn=~RESET_VAL, cnt=0, done=0.
//   - Reset asserted mid-operation aborts the current operation. No partial update survives.
//   - After rst_n rises, the first rising clk edge performs a normal operation.
//   Update timing
//   - All updates are registered: one-cycle latency from the sampled inputs to q/cnt/done.
//   - qn, sout_r, sout_l and done are combinational functions of registered state. No extra delay.
//   Enable
//   - en=0: q and cnt hold, regardless of mode.
//   Mode decode (when en=1)
//   - 000 HOLD : q unchanged, cnt unchanged
//   - 001 SHR  : q <= {sin_r, q[WIDTH-1:1]}
//   - 010 SHL  : q <= {q[WIDTH-2:0], sin_l}
//   - 011 LOAD : q <= d, cnt <= 0
//   - 100 ROR  : q <= {q[0], q[WIDTH-1:1]}
//   - 101 ROL  : q <= {q[WIDTH-2:0], q[WIDTH-1]}
//   - 110 CLR  : q <= 0, cnt <= 0
//   - 111      : reserved, behaves as HOLD
//   Counter
//   - SHR/SHL/ROR/ROL increment cnt.
//   - cnt saturates at WIDTH and never wraps. Further shifts leave cnt=WIDTH and done=1.
//   - LOAD/CLR always clear cnt, including when cnt is saturated.
//   Serial-in sampling
//   - sin_r and sin_l are sampled only in their own mode. Otherwise they are ignored.
//   Serial-out timing
//   - sout_r/sout_l show the bit that the next SHR/SHL will discard.
//   Widths
//   - No truncation on q.
//   - cnt width holds 0..WIDTH inclusive.
// TESTING (WIDTH=8, RESET_VAL=8'h00)
//   1. Async reset
//      Drive rst_n=0 between clk edges while q=8'hA5.
//      -> q=00, qn=FF, cnt=0, done=0 immediately, without waiting for an edge.
//   2. Load then SHR
//      LOAD d=8'hB4, then 8x SHR with sin_r=0.
//      -> q: B4,5A,2D,16,0B,05,02,01,00.
//      -> sout_r sequence 0,0,1,0,1,1,0,1.
//      -> done=1 after the 8th shift.
//   3. Rotate
//      LOAD 8'h81, then ROL x1 -> 03.
//      Then ROR x2 -> 81 -> C0.
//      -> cnt=3 at the end.
//   4. Saturation and clear
//      10x SHL with sin_l=1 from q=00.
//      -> q=FF, cnt stays 8, done=1.
//      Then CLR -> q=00, cnt=0, done=0.
//   5. Enable / reserved mode
//      en=0 with mode=SHR for 3 cycles -> q and cnt unchanged.
//      en=1 with mode=111 -> unchanged.
//   6. Reset mid-stream
//      After 4 SHR from B4, pulse rst_n low.
//      -> q=00, cnt=0.
//      Release rst_n, then LOAD 3C -> q=3C next edge.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: load, clear, shift, rotate, with a
// saturating shift counter that flags a fully serialised word.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             shift;

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    shift = 1'b0;
    if (en) begin
      unique case (mode)
        M_SHR: begin
          q_d   = {sin_r, q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        M_SHL: begin
          q_d   = {q_q[WIDTH-2:0], sin_l};
          shift = 1'b1;
        end
        M_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        M_ROR: begin
          q_d   = {q_q[0], q_q[WIDTH-1:1]};
          shift = 1'b1;
        end
        M_ROL: begin
          q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          shift = 1'b1;
        end
        M_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
        M_HOLD: ;
        default: ;
      endcase
      // counter saturates so done stays up until the next load/clear
      if (shift && cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= RESET_VAL;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

  assign q      = q_q;
  assign qn     = ~q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign cnt    = cnt_q;
  assign done   = (cnt_q == CNT_MAX);

endmodule
